// File: rtl/parallel_sequence_inserter_pkg.sv
// Shared definitions for the parallel sequence inserter / detector pair.
// State encoding and the bit-order convention both sides agree on.
package parallel_sequence_inserter_pkg;

  typedef enum logic [1:0] {
    STS_Idle   = 2'd0,
    STS_Stream = 2'd1,
    STS_Flush  = 2'd2
  } psi_state_e;

  // MSB of every word (payload, pattern, output) is the earliest bit in time.
  localparam bit PSI_MSB_FIRST = 1'b1;

endpackage

// File: rtl/parallel_sequence_inserter.sv
// Transmit-side framer: offset zero fill, marker pattern, then payload words
// bit-packed across word boundaries, in the order the detector consumes.
module parallel_sequence_inserter
  import parallel_sequence_inserter_pkg::*;
#(
  parameter  int WID_Bitstream = 8,
  parameter  int WID_Compair   = 4,
  localparam int WID_Offset    = $clog2(WID_Bitstream),
  localparam int WID_Buffer    = 2 * WID_Bitstream,
  localparam int WID_Count     = $clog2(WID_Buffer + 1)
) (
  input  logic                     local_PSD_clk,
  input  logic                     local_PSD_reset,
  input  logic                     local_PSI_newstream,
  input  logic [WID_Compair-1:0]   local_PSI_compair,
  input  logic [WID_Offset-1:0]    local_PSI_offset,
  input  logic                     local_PSI_valid,
  input  logic [WID_Bitstream-1:0] local_PSI_payload,
  output logic                     PSI_local_ready,
  input  logic                     local_PSI_endstream,
  output logic                     PSI_local_busy,
  output logic                     PSI_local_valid,
  output logic [WID_Bitstream-1:0] PSI_local_word
);

  localparam logic [WID_Count-1:0] W_CNT = WID_Count'(WID_Bitstream);

  psi_state_e             state;
  logic [WID_Buffer-1:0]  buffer;
  logic [WID_Count-1:0]   count;

  logic                   emit, accept;
  logic [WID_Count-1:0]   remain;
  logic [WID_Buffer-1:0]  shifted, start_buf;
  logic [WID_Count-1:0]   start_count;

  // Drop a word in right behind the pos valid bits of an MSB-aligned buffer.
  // Bits below the valid region are always zero, so OR is a safe append.
  function automatic logic [WID_Buffer-1:0] append_word(
    input logic [WID_Buffer-1:0]    base,
    input logic [WID_Bitstream-1:0] word,
    input logic [WID_Count-1:0]     pos
  );
    return base | ({word, {WID_Bitstream{1'b0}}} >> pos);
  endfunction

  assign PSI_local_ready = (state == STS_Stream);
  assign PSI_local_busy  = (state != STS_Idle);

  assign emit    = (count >= W_CNT);
  assign accept  = local_PSI_valid && PSI_local_ready;
  assign remain  = emit ? (count - W_CNT) : count;
  assign shifted = emit ? (buffer << WID_Bitstream) : buffer;

  assign start_buf   = {local_PSI_compair, {(WID_Buffer-WID_Compair){1'b0}}} >> local_PSI_offset;
  assign start_count = WID_Count'(local_PSI_offset) + WID_Count'(WID_Compair);

  always_ff @(posedge local_PSD_clk or posedge local_PSD_reset) begin
    if (local_PSD_reset) begin
      state           <= STS_Idle;
      buffer          <= '0;
      count           <= '0;
      PSI_local_valid <= 1'b0;
      PSI_local_word  <= '0;
    end else begin
      case (state)
        STS_Idle: begin
          PSI_local_valid <= 1'b0;
          if (local_PSI_newstream) begin
            buffer <= start_buf;
            count  <= start_count;
            state  <= STS_Stream;
          end
        end

        STS_Stream: begin
          PSI_local_valid <= emit;
          if (emit) PSI_local_word <= buffer[WID_Buffer-1 -: WID_Bitstream];
          // remain <= W-1 here, so remain+W never overflows the buffer.
          buffer <= accept ? append_word(shifted, local_PSI_payload, remain) : shifted;
          count  <= accept ? (remain + W_CNT) : remain;
          if (local_PSI_endstream) state <= STS_Flush;
        end

        STS_Flush: begin
          if (emit) begin
            PSI_local_valid <= 1'b1;
            PSI_local_word  <= buffer[WID_Buffer-1 -: WID_Bitstream];
            buffer          <= shifted;
            count           <= remain;
          end else if (count != '0) begin
            // Tail word: the unused LSBs are already zero in the buffer.
            PSI_local_valid <= 1'b1;
            PSI_local_word  <= buffer[WID_Buffer-1 -: WID_Bitstream];
            buffer          <= '0;
            count           <= '0;
            state           <= STS_Idle;
          end else begin
            PSI_local_valid <= 1'b0;
            state           <= STS_Idle;
          end
        end

        default: begin
          PSI_local_valid <= 1'b0;
          state           <= STS_Idle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_parallel_sequence_inserter.sv
// Bench for parallel_sequence_inserter: bit-queue reference model, directed
// framing cases, reset abort, starvation bubbles and randomized streams.
module tb_parallel_sequence_inserter;
  localparam int W = 8;
  localparam int C = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         ns, vld, es;
  logic [C-1:0] pat;
  logic [2:0]   off;
  logic [W-1:0] pl;
  logic         ready, busy, ovalid;
  logic [W-1:0] oword;

  always #5 clk = ~clk;

  parallel_sequence_inserter #(.WID_Bitstream(W), .WID_Compair(C)) dut (
    .local_PSD_clk       (clk),
    .local_PSD_reset     (rst),
    .local_PSI_newstream (ns),
    .local_PSI_compair   (pat),
    .local_PSI_offset    (off),
    .local_PSI_valid     (vld),
    .local_PSI_payload   (pl),
    .PSI_local_ready     (ready),
    .local_PSI_endstream (es),
    .PSI_local_busy      (busy),
    .PSI_local_valid     (ovalid),
    .PSI_local_word      (oword)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: pending bits in time order, plus a mode (0 idle, 1 stream, 2 flush).
  bit           q[$];
  bit           expbits[$];
  bit           gotbits[$];
  logic [W-1:0] got_words[$];
  int           m_st = 0;
  logic [W-1:0] exp_word = '0;
  logic         exp_vld = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic i_ns, input logic [C-1:0] i_pat, input logic [2:0] i_off,
                     input logic i_v, input logic [W-1:0] i_pl, input logic i_es);
    ns = i_ns; pat = i_pat; off = i_off; vld = i_v; pl = i_pl; es = i_es;
    #1;
    chk("ready", ready, m_st == 1);
    exp_vld = 1'b0;
    case (m_st)
      0: if (i_ns) begin
        q.delete();
        for (int i = 0; i < i_off; i++) begin q.push_back(1'b0); expbits.push_back(1'b0); end
        for (int i = C-1; i >= 0; i--) begin q.push_back(i_pat[i]); expbits.push_back(i_pat[i]); end
        m_st = 1;
      end
      1: begin
        if (q.size() >= W) begin
          for (int i = W-1; i >= 0; i--) exp_word[i] = q.pop_front();
          exp_vld = 1'b1;
        end
        if (i_v)
          for (int i = W-1; i >= 0; i--) begin q.push_back(i_pl[i]); expbits.push_back(i_pl[i]); end
        if (i_es) m_st = 2;
      end
      default: begin
        if (q.size() >= W) begin
          for (int i = W-1; i >= 0; i--) exp_word[i] = q.pop_front();
          exp_vld = 1'b1;
        end else if (q.size() > 0) begin
          exp_word = '0;
          for (int i = W-1; q.size() > 0; i--) exp_word[i] = q.pop_front();
          exp_vld = 1'b1;
          m_st = 0;
        end else m_st = 0;
      end
    endcase
    @(posedge clk); #1;
    chk("valid", ovalid, exp_vld);
    chk("word", oword, exp_word);
    chk("busy", busy, m_st != 0);
    if (ovalid === 1'b1) begin
      got_words.push_back(oword);
      for (int i = W-1; i >= 0; i--) gotbits.push_back(oword[i]);
    end
  endtask

  task automatic idle_until_done(input string tag);
    int n = 0;
    while (m_st != 0 && n < 8) begin cyc(0, '0, '0, 0, '0, 0); n++; end
    chk({tag, "_drain"}, m_st, 0);
    cyc(0, '0, '0, 0, '0, 0);
  endtask

  task automatic new_log();
    expbits.delete(); gotbits.delete(); got_words.delete();
  endtask

  // Compare the whole emitted bit stream against framing + payload, zero-padded.
  task automatic check_stream(input string tag);
    int mism = 0;
    while (expbits.size() % W != 0) expbits.push_back(1'b0);
    chk({tag, "_len"}, gotbits.size(), expbits.size());
    for (int i = 0; i < expbits.size() && i < gotbits.size(); i++)
      if (gotbits[i] != expbits[i]) mism++;
    chk({tag, "_bits"}, mism, 0);
  endtask

  task automatic check_marker(input string tag, input logic [2:0] o, input logic [C-1:0] p);
    logic [31:0] v = '0;
    for (int i = 0; i < o + C && i < gotbits.size(); i++) v = {v[30:0], gotbits[i]};
    chk({tag, "_marker"}, v, {28'd0, p});
  endtask

  initial begin
    logic [C-1:0] rp;
    logic [2:0]   ro;
    int           np;
    ns = 0; pat = '0; off = '0; vld = 0; pl = '0; es = 0;
    rst = 1'b1;
    #3;
    chk("rst_valid", ovalid, 0);
    chk("rst_word", oword, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", ready, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Offset 0, pattern 1011, payload A5 then 3C with endstream.
    new_log();
    cyc(1, 4'b1011, 3'd0, 0, '0, 0);
    cyc(0, '0, '0, 1, 8'hA5, 0);
    cyc(0, '0, '0, 1, 8'h3C, 1);
    idle_until_done("t2");
    chk("t2_n", got_words.size(), 3);
    if (got_words.size() == 3) begin
      chk("t2_w0", got_words[0], 8'hBA);
      chk("t2_w1", got_words[1], 8'h53);
      chk("t2_w2", got_words[2], 8'hC0);
    end

    // Offset 3, single payload FF with endstream.
    new_log();
    cyc(1, 4'b1011, 3'd3, 0, '0, 0);
    cyc(0, '0, '0, 1, 8'hFF, 1);
    idle_until_done("t3");
    chk("t3_n", got_words.size(), 2);
    if (got_words.size() == 2) begin
      chk("t3_w0", got_words[0], 8'h17);
      chk("t3_w1", got_words[1], 8'hFE);
    end

    // Offset 4, endstream with no payload: a single full marker word.
    new_log();
    cyc(1, 4'b1011, 3'd4, 0, '0, 0);
    cyc(0, '0, '0, 0, '0, 1);
    idle_until_done("t4");
    chk("t4_n", got_words.size(), 1);
    if (got_words.size() == 1) chk("t4_w0", got_words[0], 8'h0B);

    // Starvation: three idle payload cycles mid-stream, stream must be intact.
    new_log();
    cyc(1, 4'b0110, 3'd2, 0, '0, 0);
    cyc(0, '0, '0, 1, 8'h5A, 0);
    cyc(0, '0, '0, 1, 8'hC3, 0);
    repeat (3) cyc(0, '0, '0, 0, 8'hEE, 0);
    cyc(0, '0, '0, 1, 8'h81, 1);
    idle_until_done("t5");
    check_stream("t5");
    check_marker("t5", 3'd2, 4'b0110);

    // Reset mid-stream: outputs must clear before the next edge.
    cyc(1, 4'b1001, 3'd1, 0, '0, 0);
    cyc(0, '0, '0, 1, 8'h77, 0);
    cyc(0, '0, '0, 1, 8'h12, 0);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", ovalid, 0);
    chk("arst_word", oword, 0);
    chk("arst_busy", busy, 0);
    chk("arst_ready", ready, 0);
    q.delete(); m_st = 0; exp_word = '0;
    rst = 1'b0;
    cyc(0, '0, '0, 0, '0, 0);

    // Randomized streams with gaps and stray newstream pulses while busy.
    for (int s = 0; s < 12; s++) begin
      new_log();
      rp = C'($urandom);
      ro = 3'($urandom_range(0, W-1));
      np = $urandom_range(0, 6);
      cyc(1, rp, ro, 0, '0, 0);
      for (int k = 0; k < np; k++) begin
        while ($urandom_range(0, 3) == 0)
          cyc($urandom_range(0, 1) == 1, ~rp, 3'($urandom), 0, W'($urandom), 0);
        cyc($urandom_range(0, 2) == 0, ~rp, 3'($urandom), 1, W'($urandom), 0);
      end
      cyc(0, '0, '0, $urandom_range(0, 1) == 1, W'($urandom), 1);
      idle_until_done("rnd");
      check_stream("rnd");
      check_marker("rnd", ro, rp);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
